// File: rtl/spi_sensor_seq.sv
// -----------------------------------------------------------------------------
// spi_sensor_seq
//   SPI sensor sequencer. The sequencer first probes the sensor ID. It then
//   writes one config register and reads it back to verify it. After that it
//   polls a data register every POLL_PERIOD clocks. Each SPI transaction goes
//   to a byte-level SPI master through a start/done handshake. Failed steps
//   are retried up to RETRY_MAX times. After that the sequencer parks in
//   S_ERROR until reset.
//
// Optional feature macro: FAULT_CHECK_EN
//   When defined, bit 0 of a data read is the sensor fault flag. A faulty
//   read does not update the sample and counts as a failed step. The macro
//   also adds the 'fault' output.
//
// Ports
//   sys_clk_pin    in   1   clock
//   rst            in   1   synchronous active-high reset
//   spi_start      out  1   one-cycle pulse launching an SPI transaction
//   spi_done       in   1   one-cycle pulse, transaction complete
//   spi_in_count   out  4   bytes to transmit
//   spi_out_count  out  4   bytes to receive
//   spi_in_bytes   out  32  tx data, [7:0] sent first
//   spi_out_bytes  in   32  rx data, last received byte in [7:0]
//   sample         out  32  latest data word, zero-extended
//   sample_valid   out  1   one-cycle pulse when sample updates
//   state          out  3   current sequencer state
//   fault          out  1   sensor fault flag (FAULT_CHECK_EN builds only)
//   err            out  1   sticky error flag
// -----------------------------------------------------------------------------
module spi_sensor_seq #(
    parameter logic [7:0] ID_ADDR     = 8'h07,
    parameter logic [7:0] ID_VAL      = 8'h03,
    parameter logic [7:0] CFG_ADDR    = 8'h00,
    parameter logic [7:0] CFG_VAL     = 8'h81,
    parameter logic [7:0] DATA_ADDR   = 8'h01,
    parameter int         DATA_BYTES  = 2,
    parameter int         POLL_PERIOD = 1000000,
    parameter int         RETRY_MAX   = 3,
    parameter int         TIMEOUT     = 65535
) (
    input  logic        sys_clk_pin,
    input  logic        rst,
    output logic        spi_start,
    input  logic        spi_done,
    output logic [3:0]  spi_in_count,
    output logic [3:0]  spi_out_count,
    output logic [31:0] spi_in_bytes,
    input  logic [31:0] spi_out_bytes,
    output logic [31:0] sample,
    output logic        sample_valid,
    output logic [2:0]  state,
`ifdef FAULT_CHECK_EN
    output logic        fault,
`endif
    output logic        err
);

    typedef enum logic [2:0] {
        S_PROBE  = 3'd0,
        S_CFG_WR = 3'd1,
        S_CFG_RD = 3'd2,
        S_WAIT   = 3'd3,
        S_READ   = 3'd4,
        S_ERROR  = 3'd7
    } state_t;

    typedef enum logic {
        PH_ISSUE = 1'b0,
        PH_PEND  = 1'b1
    } phase_t;

    // One timer serves both the poll wait and the transaction timeout.
    localparam int TIMER_MAX = (POLL_PERIOD > TIMEOUT) ? POLL_PERIOD : TIMEOUT;
    localparam int TW        = $clog2(TIMER_MAX + 1);
    localparam int RW        = $clog2(RETRY_MAX + 2);

    localparam logic [TW-1:0] POLL_LAST    = TW'(POLL_PERIOD - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(RETRY_MAX);

    // Keeps only the DATA_BYTES low bytes of a data read.
    function automatic logic [31:0] data_mask(input int nbytes);
        logic [31:0] m;
        m = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            if (i < nbytes) begin
                m[8*i +: 8] = 8'hFF;
            end else begin
                m[8*i +: 8] = 8'h00;
            end
        end
        return m;
    endfunction

    localparam logic [31:0] DATA_MASK = data_mask(DATA_BYTES);

    state_t        state_r, state_n;
    phase_t        phase_r, phase_n;
    logic [RW-1:0] retry_r, retry_n;
    logic [TW-1:0] timer_r, timer_n;
    logic          start_r, start_n;
    logic [3:0]    in_count_r, in_count_n;
    logic [3:0]    out_count_r, out_count_n;
    logic [31:0]   in_bytes_r, in_bytes_n;
    logic [31:0]   sample_r, sample_n;
    logic          valid_r, valid_n;
    logic          err_r, err_n;
`ifdef FAULT_CHECK_EN
    logic          fault_r, fault_n;
`endif

    logic [3:0]    tx_in_count_s;
    logic [3:0]    tx_out_count_s;
    logic [31:0]   tx_bytes_s;
    logic          pass_s;
    logic          pass_clears_s;
    state_t        pass_state_s;
    state_t        mismatch_state_s;
    logic          fail_now_s;
    state_t        fail_target_s;

    // Transmit fields for the transaction owned by the current state.
    always_comb begin
        tx_in_count_s  = 4'd0;
        tx_out_count_s = 4'd0;
        tx_bytes_s     = 32'h0000_0000;
        case (state_r)
            S_PROBE: begin
                tx_in_count_s  = 4'd1;
                tx_out_count_s = 4'd1;
                tx_bytes_s     = {24'h00_0000, ID_ADDR};
            end
            S_CFG_WR: begin
                tx_in_count_s  = 4'd2;
                tx_out_count_s = 4'd0;
                tx_bytes_s     = {16'h0000, CFG_VAL, CFG_ADDR | 8'h80};
            end
            S_CFG_RD: begin
                tx_in_count_s  = 4'd1;
                tx_out_count_s = 4'd1;
                tx_bytes_s     = {24'h00_0000, CFG_ADDR};
            end
            S_READ: begin
                tx_in_count_s  = 4'd1;
                tx_out_count_s = 4'(DATA_BYTES);
                tx_bytes_s     = {24'h00_0000, DATA_ADDR};
            end
            default: begin
                tx_in_count_s  = 4'd0;
                tx_out_count_s = 4'd0;
                tx_bytes_s     = 32'h0000_0000;
            end
        endcase
    end

    // Judges a completed transaction and picks the success / mismatch targets.
    always_comb begin
        pass_s           = 1'b0;
        pass_clears_s    = 1'b0;
        pass_state_s     = S_ERROR;
        mismatch_state_s = S_ERROR;
        case (state_r)
            S_PROBE: begin
                pass_s           = (spi_out_bytes[7:0] == ID_VAL);
                pass_clears_s    = 1'b1;
                pass_state_s     = S_CFG_WR;
                mismatch_state_s = S_PROBE;
            end
            S_CFG_WR: begin
                // The write has nothing to verify. It does not clear retry,
                // so WR/RD loops share one budget.
                pass_s           = 1'b1;
                pass_clears_s    = 1'b0;
                pass_state_s     = S_CFG_RD;
                mismatch_state_s = S_CFG_WR;
            end
            S_CFG_RD: begin
                pass_s           = (spi_out_bytes[7:0] == CFG_VAL);
                pass_clears_s    = 1'b1;
                pass_state_s     = S_WAIT;
                mismatch_state_s = S_CFG_WR;
            end
            S_READ: begin
`ifdef FAULT_CHECK_EN
                pass_s           = ~spi_out_bytes[0];
`else
                pass_s           = 1'b1;
`endif
                pass_clears_s    = 1'b1;
                pass_state_s     = S_WAIT;
                mismatch_state_s = S_READ;
            end
            default: begin
                pass_s           = 1'b0;
                pass_clears_s    = 1'b0;
                pass_state_s     = S_ERROR;
                mismatch_state_s = S_ERROR;
            end
        endcase
    end

    // Failure detection while pending. If done and the last timeout cycle
    // coincide, done wins. A timeout re-runs the same step.
    always_comb begin
        if (phase_r == PH_PEND) begin
            if (spi_done) begin
                fail_now_s    = ~pass_s;
                fail_target_s = mismatch_state_s;
            end else begin
                fail_now_s    = (timer_r == TIMEOUT_LAST);
                fail_target_s = state_r;
            end
        end else begin
            fail_now_s    = 1'b0;
            fail_target_s = state_r;
        end
    end

    // Next-state and registered-output logic of the sequencer.
    always_comb begin
        state_n     = state_r;
        phase_n     = phase_r;
        retry_n     = retry_r;
        timer_n     = timer_r;
        start_n     = 1'b0;
        in_count_n  = in_count_r;
        out_count_n = out_count_r;
        in_bytes_n  = in_bytes_r;
        sample_n    = sample_r;
        valid_n     = 1'b0;
        err_n       = err_r;
        case (state_r)
            S_PROBE, S_CFG_WR, S_CFG_RD, S_READ: begin
                if (phase_r == PH_ISSUE) begin
                    start_n     = 1'b1;
                    phase_n     = PH_PEND;
                    timer_n     = {TW{1'b0}};
                    in_count_n  = tx_in_count_s;
                    out_count_n = tx_out_count_s;
                    in_bytes_n  = tx_bytes_s;
                end else if (fail_now_s) begin
                    if (retry_r >= RETRY_LIMIT) begin
                        state_n = S_ERROR;
                        err_n   = 1'b1;
                    end else begin
                        retry_n = retry_r + RW'(1);
                        state_n = fail_target_s;
                    end
                    phase_n = PH_ISSUE;
                    timer_n = {TW{1'b0}};
                end else if (spi_done) begin
                    state_n = pass_state_s;
                    phase_n = PH_ISSUE;
                    timer_n = {TW{1'b0}};
                    if (pass_clears_s) begin
                        retry_n = {RW{1'b0}};
                    end else begin
                        retry_n = retry_r;
                    end
                    if (state_r == S_READ) begin
                        sample_n = spi_out_bytes & DATA_MASK;
                        valid_n  = 1'b1;
                    end else begin
                        sample_n = sample_r;
                    end
                end else begin
                    timer_n = timer_r + TW'(1);
                end
            end
            S_WAIT: begin
                if (timer_r == POLL_LAST) begin
                    state_n = S_READ;
                    phase_n = PH_ISSUE;
                    timer_n = {TW{1'b0}};
                end else begin
                    timer_n = timer_r + TW'(1);
                end
            end
            S_ERROR: begin
                err_n   = 1'b1;
                phase_n = PH_ISSUE;
            end
            default: begin
                state_n = S_ERROR;
                phase_n = PH_ISSUE;
                err_n   = 1'b1;
            end
        endcase
    end

`ifdef FAULT_CHECK_EN
    // A completed data read updates the fault flag from rx bit 0. Timeouts leave it unchanged.
    always_comb begin
        if ((state_r == S_READ) && (phase_r == PH_PEND) && spi_done) begin
            fault_n = spi_out_bytes[0];
        end else begin
            fault_n = fault_r;
        end
    end
`endif

    // State and output registers with synchronous reset.
    always_ff @(posedge sys_clk_pin) begin
        if (rst) begin
            state_r     <= S_PROBE;
            phase_r     <= PH_ISSUE;
            retry_r     <= {RW{1'b0}};
            timer_r     <= {TW{1'b0}};
            start_r     <= 1'b0;
            in_count_r  <= 4'd0;
            out_count_r <= 4'd0;
            in_bytes_r  <= 32'h0000_0000;
            sample_r    <= 32'h0000_0000;
            valid_r     <= 1'b0;
            err_r       <= 1'b0;
`ifdef FAULT_CHECK_EN
            fault_r     <= 1'b0;
`endif
        end else begin
            state_r     <= state_n;
            phase_r     <= phase_n;
            retry_r     <= retry_n;
            timer_r     <= timer_n;
            start_r     <= start_n;
            in_count_r  <= in_count_n;
            out_count_r <= out_count_n;
            in_bytes_r  <= in_bytes_n;
            sample_r    <= sample_n;
            valid_r     <= valid_n;
            err_r       <= err_n;
`ifdef FAULT_CHECK_EN
            fault_r     <= fault_n;
`endif
        end
    end

    assign spi_start     = start_r;
    assign spi_in_count  = in_count_r;
    assign spi_out_count = out_count_r;
    assign spi_in_bytes  = in_bytes_r;
    assign sample        = sample_r;
    assign sample_valid  = valid_r;
    assign state         = state_r;
    assign err           = err_r;
`ifdef FAULT_CHECK_EN
    assign fault         = fault_r;
`endif

endmodule

// File: tb/tb_spi_sensor_seq.sv
// Testbench for spi_sensor_seq: an SPI slave model answers transactions, a
// scoreboard queue holds the expected transactions and samples, and a monitor
// compares whatever the DUT presents against the queue heads.
module tb_spi_sensor_seq;

    localparam int POLL = 20;
    localparam int TMO  = 16;

    logic        clk;
    logic        rst;
    logic        spi_start;
    logic        spi_done;
    logic [3:0]  spi_in_count;
    logic [3:0]  spi_out_count;
    logic [31:0] spi_in_bytes;
    logic [31:0] spi_out_bytes;
    logic [31:0] sample;
    logic        sample_valid;
    logic [2:0]  state;
    logic        err;
`ifdef FAULT_CHECK_EN
    logic        fault;
`endif

    spi_sensor_seq #(
        .DATA_BYTES (2),
        .POLL_PERIOD(POLL),
        .RETRY_MAX  (3),
        .TIMEOUT    (TMO)
    ) dut (
        .sys_clk_pin  (clk),
        .rst          (rst),
        .spi_start    (spi_start),
        .spi_done     (spi_done),
        .spi_in_count (spi_in_count),
        .spi_out_count(spi_out_count),
        .spi_in_bytes (spi_in_bytes),
        .spi_out_bytes(spi_out_bytes),
        .sample       (sample),
        .sample_valid (sample_valid),
        .state        (state),
`ifdef FAULT_CHECK_EN
        .fault        (fault),
`endif
        .err          (err)
    );

    typedef struct packed {
        logic [2:0]  st;
        logic [3:0]  ic;
        logic [3:0]  oc;
        logic [31:0] tx;
    } txn_t;

    txn_t        exp_txn_q[$];
    logic [31:0] exp_smp_q[$];
    logic [31:0] data_q[$];
    int          start_cyc[$];

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int n_valid = 0;
    int done_cyc = 0;

    // slave model knobs
    int lat        = 3;
    bit no_done    = 1'b0;
    int probe_fail = 0;
    int cfg_fail   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic void exp_probe();
        exp_txn_q.push_back({3'd0, 4'd1, 4'd1, 32'h0000_0007});
    endfunction
    function automatic void exp_cfg_wr();
        exp_txn_q.push_back({3'd1, 4'd2, 4'd0, 32'h0000_8180});
    endfunction
    function automatic void exp_cfg_rd();
        exp_txn_q.push_back({3'd2, 4'd1, 4'd1, 32'h0000_0000});
    endfunction
    function automatic void exp_read();
        exp_txn_q.push_back({3'd4, 4'd1, 4'd2, 32'h0000_0001});
    endfunction

    // Slave model: answers each start after 'lat' cycles. Upper bytes carry
    // junk so the DUT must look only at the bytes that matter.
    initial begin
        logic [7:0]  addr;
        logic [3:0]  oc;
        logic [31:0] r;
        spi_done      = 1'b0;
        spi_out_bytes = 32'h0000_0000;
        forever begin
            @(negedge clk);
            spi_done = 1'b0;
            if (spi_start === 1'b1 && !no_done) begin
                addr = spi_in_bytes[7:0];
                oc   = spi_out_count;
                repeat (lat) @(negedge clk);
                r = 32'h0000_0000;
                if (oc != 4'd0) begin
                    case (addr)
                        8'h07: begin
                            if (probe_fail > 0) begin probe_fail--; r = 32'hFFFF_FF00; end
                            else r = 32'hFFFF_FF03;
                        end
                        8'h00: begin
                            if (cfg_fail > 0) begin cfg_fail--; r = 32'hFFFF_FF80; end
                            else r = 32'hFFFF_FF81;
                        end
                        8'h01: begin
                            if (data_q.size() > 0) r = data_q.pop_front();
                            else r = 32'hABCD_1234;
                        end
                        default: r = 32'h0000_0000;
                    endcase
                end
                spi_out_bytes = r;
                spi_done      = 1'b1;
                done_cyc      = cyc;
            end
        end
    end

    // Monitor: every start and every sample pulse is checked against the scoreboard.
    initial begin
        txn_t        e;
        logic [31:0] s;
        forever begin
            @(negedge clk);
            if (spi_start === 1'b1) begin
                start_cyc.push_back(cyc);
                if (exp_txn_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start: state %0d tx %0h, none expected", state, spi_in_bytes);
                end else begin
                    e = exp_txn_q.pop_front();
                    check("txn", 128'({state, spi_in_count, spi_out_count, spi_in_bytes}), 128'(e));
                end
            end
            if (sample_valid === 1'b1) begin
                n_valid++;
                if (exp_smp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sample: got %0h, none expected", sample);
                end else begin
                    s = exp_smp_q.pop_front();
                    check("sample", 128'(sample), 128'(s));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int k = 0;
        while (state !== s && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 128'(state), 128'(s));
    endtask

    task automatic wait_valid(input int n, input int budget, input string name);
        int k = 0;
        while (n_valid < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 128'(n_valid), 128'(n));
    endtask

    function automatic void check_reset_vals(input string name);
        check(name, 128'({state, spi_start, spi_in_count, spi_out_count, spi_in_bytes,
                          sample, sample_valid, err}), 128'h0);
`ifdef FAULT_CHECK_EN
        check({name, "_fault"}, 128'(fault), 128'h0);
`endif
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        exp_txn_q.delete();
        exp_smp_q.delete();
        data_q.delete();
        start_cyc.delete();
        probe_fail = 0;
        cfg_fail   = 0;
        no_done    = 1'b0;
        lat        = 3;
    endtask

    initial begin
        int t1_done;
        int s;
        int nv;
        int k;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset_initial");

        // 1: full bring-up then two polls, poll spacing exact
        exp_probe(); exp_cfg_wr(); exp_cfg_rd(); exp_read();
        exp_smp_q.push_back(32'h0000_1234);
        rst = 1'b0;
        wait_state(3'd3, 60, "t1_wait_reached");
        wait_valid(1, 100, "t1_first_valid");
        check("t1_sample", 128'(sample), 128'h1234);
        check("t1_err", 128'(err), 128'h0);
        t1_done = done_cyc;
        exp_read();
        data_q.push_back(32'h9999_5678);
        exp_smp_q.push_back(32'h0000_5678);
        wait_valid(2, 100, "t1_second_valid");
        check("t1_poll_gap", 128'((start_cyc.size() > 4) ? start_cyc[4] - t1_done : -1), 128'(POLL + 2));

        // 2: probe keeps failing, four attempts then error
        do_reset();
        check_reset_vals("t2_reset");
        probe_fail = 100;
        exp_probe(); exp_probe(); exp_probe(); exp_probe();
        rst = 1'b0;
        wait_state(3'd7, 200, "t2_error_state");
        check("t2_err", 128'(err), 128'h1);
        check("t2_starts", 128'(start_cyc.size()), 128'd4);
        repeat (40) @(negedge clk);
        check("t2_no_more_starts", 128'(start_cyc.size()), 128'd4);

        // 3: one config readback mismatch -> WR,RD,WR,RD then wait
        do_reset();
        cfg_fail = 1;
        exp_probe(); exp_cfg_wr(); exp_cfg_rd(); exp_cfg_wr(); exp_cfg_rd();
        rst = 1'b0;
        wait_state(3'd3, 100, "t3_wait_reached");
        check("t3_err", 128'(err), 128'h0);
        check("t3_all_txns_seen", 128'(exp_txn_q.size()), 128'd0);

        // 4: no done ever, TIMEOUT=16 -> starts 17 clocks apart, error after 4th
        do_reset();
        no_done = 1'b1;
        exp_probe(); exp_probe(); exp_probe(); exp_probe();
        rst = 1'b0;
        wait_state(3'd7, 200, "t4_error_state");
        check("t4_err", 128'(err), 128'h1);
        for (int i = 1; i < 4; i++) begin
            check("t4_retry_gap", 128'((start_cyc.size() > i) ? start_cyc[i] - start_cyc[i-1] : -1), 128'd17);
        end

        // 5: reset 3 cycles into READ pending, spurious done right after release
        do_reset();
        lat = 5;
        exp_probe(); exp_cfg_wr(); exp_cfg_rd(); exp_read();
        rst = 1'b0;
        k = 0;
        while (start_cyc.size() < 4 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("t5_read_started", 128'(start_cyc.size()), 128'd4);
        if (start_cyc.size() >= 4) begin
            s  = start_cyc[3];
            nv = n_valid;
            while (cyc < s + 2) @(negedge clk);
            rst = 1'b1;
            while (cyc < s + 4) @(negedge clk);
            check_reset_vals("t5_reset_mid_read");
            exp_txn_q.delete();
            exp_probe(); exp_cfg_wr(); exp_cfg_rd();
            @(negedge clk);
            rst = 1'b0;
            wait_state(3'd3, 100, "t5_recovered_wait");
            check("t5_no_sample", 128'(n_valid), 128'(nv));
            check("t5_err", 128'(err), 128'h0);
        end

`ifdef FAULT_CHECK_EN
        // 6: fault bit on a read blocks the sample, a clean retry restores it
        do_reset();
        data_q.push_back(32'h0000_1000);
        data_q.push_back(32'h0000_1235);
        data_q.push_back(32'h0000_1234);
        exp_probe(); exp_cfg_wr(); exp_cfg_rd(); exp_read(); exp_read(); exp_read();
        exp_smp_q.push_back(32'h0000_1000);
        exp_smp_q.push_back(32'h0000_1234);
        nv = n_valid;
        rst = 1'b0;
        wait_valid(nv + 1, 100, "t6_first_valid");
        k = 0;
        while (fault !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("t6_fault_set", 128'(fault), 128'h1);
        check("t6_sample_kept", 128'({sample_valid, sample}), 128'h1000);
        wait_valid(nv + 2, 50, "t6_clean_valid");
        check("t6_fault_clear", 128'(fault), 128'h0);
        check("t6_sample_new", 128'(sample), 128'h1234);
`endif

        do_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
